flatten_serializer: RTL

FLATTEN_SERIALIZER -- requirements
Module: flatten_serializer

---
 rtl/flatten_serializer_pkg.sv | 12 +
 rtl/flatten_serializer_if.sv | 31 +++
 rtl/flatten_serializer_frame_bank.sv | 23 ++
 rtl/flatten_serializer.sv | 95 +++++++++
 4 files changed

// File: rtl/flatten_serializer_pkg.sv
// Shared defaults and occupancy encoding for the flatten serializer.
package flatten_serializer_pkg;
  localparam int CH_DEF = 32;
  localparam int DW_DEF = 8;

  // Number of frames currently held in the ping-pong store.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;
endpackage

// File: rtl/flatten_serializer_if.sv
// Parallel-frame input stream and serial-element output stream.
interface flatten_serializer_if
  import flatten_serializer_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = $clog2(CH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [CH*DW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             drop_pulse;
  logic             busy;

  // Producer of frames / consumer of elements.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, drop_pulse, busy
  );

  // The serializer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, drop_pulse, busy
  );
endinterface

// File: rtl/flatten_serializer_frame_bank.sv
// One CH x DW frame register: whole-frame parallel write, single-element read.
module frame_bank
  import flatten_serializer_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int DW = DW_DEF,
  parameter int IW = $clog2(CH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CH*DW-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [DW-1:0]    rdata
);
  logic [CH-1:0][DW-1:0] mem;

  // Capture a full frame; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/flatten_serializer.sv
// Two-bank ping-pong store turning CH-wide frames into a stream of DW-bit
// elements tagged with their channel index.
module flatten_serializer
  import flatten_serializer_pkg::*;
#(
  parameter int CH      = CH_DEF,
  parameter int DW      = DW_DEF,
  parameter int REVERSE = 0
) (
  input logic              clk,
  input logic              rst,
  flatten_serializer_if.slave bus
);
  localparam int            IW    = $clog2(CH);
  localparam logic [IW-1:0] START = (REVERSE != 0) ? IW'(CH - 1) : '0;
  localparam logic [IW-1:0] STOP  = (REVERSE != 0) ? '0 : IW'(CH - 1);

  occ_t                  state, state_nxt;
  logic                  wr_bank, rd_bank;
  logic [IW-1:0]         ptr;
  logic                  drop_q;
  logic                  ready, valid;
  logic                  load, beat, last_beat;
  logic [1:0][DW-1:0]    bank_rd;

  // Bank b is written only when it is the write target; with one frame
  // buffered the write target is always the other bank, so a frame being
  // read is never overwritten.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(.CH(CH), .DW(DW), .IW(IW)) u_bank (
      .clk   (clk),
      .we    (load && (wr_bank == 1'(b))),
      .wdata (bus.in_data),
      .raddr (ptr),
      .rdata (bank_rd[b])
    );
  end

  assign load      = bus.in_valid & ready;
  assign beat      = valid & bus.out_ready;
  assign last_beat = beat & (ptr == STOP);

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Occupancy next state: load adds a frame, last beat retires one, both cancel.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (load) state_nxt = ONE;
      ONE: begin
        if (load && !last_beat)      state_nxt = FULL;
        else if (!load && last_beat) state_nxt = EMPTY;
      end
      FULL:  if (last_beat) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Handshake outputs depend on registered occupancy only.
  always_comb begin
    ready = (state != FULL);
    valid = (state != EMPTY);
  end

  // Bank pointers, element pointer and drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      ptr     <= START;
      drop_q  <= 1'b0;
    end else begin
      if (load) wr_bank <= ~wr_bank;
      if (last_beat) begin
        rd_bank <= ~rd_bank;
        ptr     <= START;
      end else if (beat) begin
        ptr <= (REVERSE != 0) ? ptr - IW'(1) : ptr + IW'(1);
      end
      drop_q <= bus.in_valid & ~ready;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid;
  assign bus.out_data   = bank_rd[rd_bank];
  assign bus.out_idx    = ptr;
  assign bus.out_last   = valid & (ptr == STOP);
  assign bus.drop_pulse = drop_q;
  assign bus.busy       = valid;
endmodule
